// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: frame field widths and FSM state encodings.
package boot_loader_pkg;

  localparam int unsigned BL_DATA_WIDTH  = 16;  // RAM word: one HI byte, one LO byte
  localparam int unsigned BL_ADDR_WIDTH  = 8;   // default RAM address width
  localparam int unsigned BL_BYTE_WIDTH  = 8;   // stream symbol width
  localparam int unsigned BL_LEN_WIDTH   = 16;  // LEN_HI/LEN_LO word count field
  localparam int unsigned BL_STATE_WIDTH = 3;

  localparam logic [BL_STATE_WIDTH-1:0] StLenHi  = 3'd0;
  localparam logic [BL_STATE_WIDTH-1:0] StLenLo  = 3'd1;
  localparam logic [BL_STATE_WIDTH-1:0] StDataHi = 3'd2;
  localparam logic [BL_STATE_WIDTH-1:0] StDataLo = 3'd3;
  localparam logic [BL_STATE_WIDTH-1:0] StWrite  = 3'd4;
  localparam logic [BL_STATE_WIDTH-1:0] StCsum   = 3'd5;
  localparam logic [BL_STATE_WIDTH-1:0] StDone   = 3'd6;
  localparam logic [BL_STATE_WIDTH-1:0] StError  = 3'd7;

endpackage

// File: rtl/bl_word_assembler.sv
// Datapath for the boot loader: byte registers, running XOR checksum, word index and
// remaining-word counter.
//   clk, reset        clock, asynchronous active-high reset
//   clear             restart a load: clears checksum, index and counter
//   take_hi, take_lo  latch byte_in as the HI / LO byte and fold it into the checksum
//   load_len          byte_in is LEN_LO: load the counter from {hi, byte_in}, fold checksum
//   step              a word was written: advance index, count down remaining
//   word, index       RAM write data and address
//   csum              running checksum
//   len_too_big/zero  classification of {hi, byte_in} as a word count
//   last_word         only one word remains (valid during WRITE)
module bl_word_assembler
  import boot_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = BL_ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     take_hi,
  input  logic                     take_lo,
  input  logic                     load_len,
  input  logic                     step,
  input  logic [BL_BYTE_WIDTH-1:0] byte_in,
  output logic [BL_DATA_WIDTH-1:0] word,
  output logic [ADDR_WIDTH-1:0]    index,
  output logic [BL_BYTE_WIDTH-1:0] csum,
  output logic                     len_too_big,
  output logic                     len_zero,
  output logic                     last_word
);

  localparam logic [BL_LEN_WIDTH:0] MaxWords = (BL_LEN_WIDTH+1)'(2 ** ADDR_WIDTH);

  logic [BL_BYTE_WIDTH-1:0] hi_q, lo_q, csum_q;
  logic [ADDR_WIDTH-1:0]    index_q;
  logic [ADDR_WIDTH:0]      remain_q;
  logic [BL_LEN_WIDTH-1:0]  len_word;

  // LEN_HI is parked in hi_q, so the full count is available while LEN_LO is on the bus.
  assign len_word    = {hi_q, byte_in};
  assign len_too_big = {1'b0, len_word} > MaxWords;
  assign len_zero    = (len_word == '0);
  assign last_word   = (remain_q == (ADDR_WIDTH+1)'(1));

  assign word  = {hi_q, lo_q};
  assign index = index_q;
  assign csum  = csum_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q     <= '0;
      lo_q     <= '0;
      csum_q   <= '0;
      index_q  <= '0;
      remain_q <= '0;
    end else if (clear) begin
      csum_q   <= '0;
      index_q  <= '0;
      remain_q <= '0;
    end else begin
      if (take_hi) hi_q <= byte_in;
      if (take_lo) lo_q <= byte_in;
      if (take_hi || take_lo || load_len) csum_q <= csum_q ^ byte_in;
      if (load_len) remain_q <= len_word[ADDR_WIDTH:0];
      if (step) begin
        // A full 2^ADDR_WIDTH image wraps the index back to 0 after the last word.
        index_q  <= index_q + ADDR_WIDTH'(1);
        remain_q <= remain_q - (ADDR_WIDTH+1)'(1);
      end
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Boot loader: holds the CPU in reset while it receives a framed byte stream
// (LEN_HI, LEN_LO, N x {HI, LO}, CSUM), writes the words to RAM from address 0,
// and releases the CPU only when the XOR checksum matches.
//   clk, reset            clock, asynchronous active-high reset
//   start                 from DONE/ERROR, begin a new load
//   in_valid, in_byte     byte stream input; in_ready marks acceptance
//   ram_addr, ram_din     RAM write address / data, ram_write one-cycle strobe
//   cpu_reset             high in every state but DONE
//   done, error           clean load / length overflow or checksum mismatch
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = BL_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = BL_ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [BL_BYTE_WIDTH-1:0] in_byte,
  output logic                     in_ready,
  output logic [ADDR_WIDTH-1:0]    ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_din,
  output logic                     ram_write,
  output logic                     cpu_reset,
  output logic                     done,
  output logic                     error
);

  logic [BL_STATE_WIDTH-1:0] state_q, state_d;
  logic accept;
  logic clear, take_hi, take_lo, load_len, step;
  logic len_too_big, len_zero, last_word;
  logic [BL_BYTE_WIDTH-1:0] csum;
  logic [BL_DATA_WIDTH-1:0] word;

  // Handshake outputs come from registered state only.
  assign in_ready  = (state_q == StLenHi)  || (state_q == StLenLo) ||
                     (state_q == StDataHi) || (state_q == StDataLo) ||
                     (state_q == StCsum);
  assign ram_write = (state_q == StWrite);
  assign cpu_reset = (state_q != StDone);
  assign done      = (state_q == StDone);
  assign error     = (state_q == StError);
  assign ram_din   = word;

  assign accept   = in_valid && in_ready;
  assign clear    = start && ((state_q == StDone) || (state_q == StError));
  assign take_hi  = accept && ((state_q == StLenHi) || (state_q == StDataHi));
  assign take_lo  = accept && (state_q == StDataLo);
  assign load_len = accept && (state_q == StLenLo);
  assign step     = (state_q == StWrite);

  bl_word_assembler #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_asm (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .take_hi     (take_hi),
    .take_lo     (take_lo),
    .load_len    (load_len),
    .step        (step),
    .byte_in     (in_byte),
    .word        (word),
    .index       (ram_addr),
    .csum        (csum),
    .len_too_big (len_too_big),
    .len_zero    (len_zero),
    .last_word   (last_word)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StLenHi:  if (accept) state_d = StLenLo;
      StLenLo: begin
        if (accept) begin
          if (len_too_big)   state_d = StError;
          else if (len_zero) state_d = StCsum;
          else               state_d = StDataHi;
        end
      end
      StDataHi: if (accept) state_d = StDataLo;
      StDataLo: if (accept) state_d = StWrite;
      StWrite:  state_d = last_word ? StCsum : StDataHi;
      StCsum:   if (accept) state_d = (in_byte == csum) ? StDone : StError;
      StDone, StError: if (start) state_d = StLenHi;
      default:  state_d = StLenHi;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StLenHi;
    else       state_q <= state_d;
  end

endmodule

// File: tb/tb_boot_loader.sv
module tb_boot_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_ready;
  logic [7:0]  ram_addr;
  logic [15:0] ram_din;
  logic        ram_write;
  logic        cpu_reset;
  logic        done;
  logic        error;

  boot_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_byte   (in_byte),
    .in_ready  (in_ready),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_write (ram_write),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  frame_q[$];
  logic [23:0] exp_q[$];   // {addr, data} writes the model expects, in order
  logic [23:0] obs_q[$];   // writes seen on the RAM port during the current frame

  int         m_nsend;
  bit         m_done, m_err;
  logic [7:0] m_x;

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  // Reference model: parse the frame by its rules and list the RAM writes and outcome.
  task automatic model_frame();
    int n;
    n = int'({frame_q[0], frame_q[1]});
    m_x = frame_q[0] ^ frame_q[1];
    exp_q.delete();
    if (n > 256) begin
      m_nsend = 2;
      m_done  = 1'b0;
      m_err   = 1'b1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({8'(i), frame_q[2+2*i], frame_q[3+2*i]});
      m_x = m_x ^ frame_q[2+2*i] ^ frame_q[3+2*i];
    end
    m_nsend = 2 + 2 * n + 1;
    m_done  = (frame_q[m_nsend-1] == m_x);
    m_err   = !m_done;
  endtask

  task automatic gen_frame(input int n, input bit bad);
    logic [7:0] x, b;
    frame_q.delete();
    frame_q.push_back(8'(n >> 8));
    frame_q.push_back(8'(n));
    x = 8'(n >> 8) ^ 8'(n);
    if (n <= 256) begin
      for (int i = 0; i < 2 * n; i++) begin
        b = 8'($urandom);
        frame_q.push_back(b);
        x = x ^ b;
      end
      if (bad) x = x ^ 8'($urandom_range(1, 255));
      frame_q.push_back(x);
    end
  endtask

  // Entered and left at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_byte  = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check(1'b0, "accept_timeout", 32'(in_ready), 32'h1);
    @(negedge clk);
    in_valid = 1'b0;
    in_byte  = 8'($urandom);
  endtask

  // gap < 0: random 0..2 idle cycles before each byte.
  task automatic send_bytes(input int count, input int gap);
    for (int i = 0; i < count; i++) begin
      repeat ((gap < 0) ? $urandom_range(0, 2) : gap) @(negedge clk);
      send_byte(frame_q[i]);
    end
  endtask

  task automatic run_frame(input int gap);
    obs_q.delete();
    model_frame();
    send_bytes(m_nsend, gap);
    check(done === m_done, "final_done", 32'(done), 32'(m_done));
    check(error === m_err, "final_error", 32'(error), 32'(m_err));
    check(cpu_reset === !m_done, "final_cpu_reset", 32'(cpu_reset), 32'(!m_done));
    check(in_ready === 1'b0, "final_in_ready", 32'(in_ready), 32'h0);
    check(exp_q.size() == 0, "writes_outstanding", 32'(exp_q.size()), 32'h0);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check(in_ready === 1'b1, "start_in_ready", 32'(in_ready), 32'h1);
    check(cpu_reset === 1'b1, "start_cpu_reset", 32'(cpu_reset), 32'h1);
    check(done === 1'b0 && error === 1'b0, "start_flags", {done, error}, 32'h0);
  endtask

  task automatic check_reset_values(input string tag);
    check(in_ready === 1'b1, {tag, "_in_ready"}, 32'(in_ready), 32'h1);
    check(ram_write === 1'b0, {tag, "_ram_write"}, 32'(ram_write), 32'h0);
    check(ram_addr === 8'h00, {tag, "_ram_addr"}, 32'(ram_addr), 32'h0);
    check(ram_din === 16'h0000, {tag, "_ram_din"}, 32'(ram_din), 32'h0);
    check(cpu_reset === 1'b1, {tag, "_cpu_reset"}, 32'(cpu_reset), 32'h1);
    check(done === 1'b0, {tag, "_done"}, 32'(done), 32'h0);
    check(error === 1'b0, {tag, "_error"}, 32'(error), 32'h0);
  endtask

  // Compare process: every RAM write must be the next one the model expects.
  always @(negedge clk) begin
    if (!reset) begin
      if (ram_write) begin
        obs_q.push_back({ram_addr, ram_din});
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_write", {8'h0, ram_addr, ram_din}, 32'h0);
        end else begin
          logic [23:0] e;
          e = exp_q.pop_front();
          check({ram_addr, ram_din} === e, "ram_write_word", {8'h0, ram_addr, ram_din},
                {8'h0, e});
        end
      end
      check((cpu_reset === ~done) && !(done && error) && !(ram_write && in_ready),
            "flag_consistency", {ram_write, in_ready, error, done, cpu_reset},
            {ram_write, 1'b0, error, done, ~done});
    end
  end

  initial begin
    logic [7:0] f1 [7];
    f1 = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    @(negedge clk);

    // Known frame with good checksum.
    frame_q.delete();
    foreach (f1[i]) frame_q.push_back(f1[i]);
    run_frame(-1);
    check(m_x == 8'h42, "model_csum", 32'(m_x), 32'h42);
    check(done === 1'b1 && cpu_reset === 1'b0, "lit_done", {done, cpu_reset}, 32'h2);
    check(obs_q.size() == 2, "lit_write_count", 32'(obs_q.size()), 32'h2);
    if (obs_q.size() == 2) begin
      check(obs_q[0] == 24'h001234, "lit_word0", 32'(obs_q[0]), 32'h001234);
      check(obs_q[1] == 24'h01ABCD, "lit_word1", 32'(obs_q[1]), 32'h01ABCD);
    end
    do_start();

    // Same frame, wrong checksum.
    frame_q[6] = 8'h43;
    run_frame(0);
    check(error === 1'b1 && done === 1'b0 && cpu_reset === 1'b1, "lit_bad_csum",
          {error, done, cpu_reset}, 32'h5);
    check(obs_q.size() == 2, "lit_bad_write_count", 32'(obs_q.size()), 32'h2);
    do_start();

    // Oversized length 257: error on the edge after LEN_LO, no writes.
    gen_frame(257, 1'b0);
    run_frame(-1);
    check(error === 1'b1, "lit_len257_error", 32'(error), 32'h1);
    check(obs_q.size() == 0, "lit_len257_writes", 32'(obs_q.size()), 32'h0);
    do_start();

    // Empty image.
    gen_frame(0, 1'b0);
    run_frame(-1);
    check(done === 1'b1 && obs_q.size() == 0, "lit_empty", {31'(obs_q.size()), done}, 32'h1);
    do_start();

    // Full 256-word image, in_valid toggling.
    gen_frame(256, 1'b0);
    run_frame(1);
    check(obs_q.size() == 256, "full_write_count", 32'(obs_q.size()), 32'd256);
    if (obs_q.size() == 256)
      check(obs_q[255][23:16] == 8'hFF, "full_last_addr", 32'(obs_q[255][23:16]), 32'hFF);
    check(done === 1'b1, "full_done", 32'(done), 32'h1);
    check(ram_addr === 8'h00, "full_index_wrap", 32'(ram_addr), 32'h0);
    do_start();

    // Reset while word 3 is half received.
    gen_frame(5, 1'b0);
    model_frame();
    send_bytes(9, -1);
    reset = 1'b1;
    #1;
    check_reset_values("midload");
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    gen_frame(4, 1'b0);
    run_frame(-1);
    check(done === 1'b1, "after_reset_done", 32'(done), 32'h1);
    do_start();

    // Random frames.
    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(0, 5) == 0) gen_frame($urandom_range(257, 65535), 1'b0);
      else gen_frame($urandom_range(0, 8), $urandom_range(0, 3) == 0);
      run_frame(-1);
      do_start();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
